// File: rtl/pixel_row_assembler.sv
// -----------------------------------------------------------------------------
// pixel_row_assembler
//
// Packs a stream of single pixel transfers (all channels in one transfer) into
// complete image rows of WIDTH pixels for the first convolution stage. Each
// image has HEIGHT rows. Output is double-buffered: the fill buffer collects
// the next row while the output register holds a finished row that downstream
// has not yet accepted. Every image gets a tag that wraps modulo 2^TAG_WIDTH.
//
// Ports
//   clock_i            clock, all logic on the rising edge
//   reset_i            synchronous active-high reset
//   in_pixel_i         pixel value, one VALUE_BITS field per channel
//   in_pixel_valid_i   pixel present
//   in_pixel_accept_o  pixel taken when valid and accept are both high
//   in_pixel_last_i    end-of-image marker (checked only with frame checking)
//   out_row_o          assembled row, index 0 = first pixel received
//   out_row_valid_o    row present
//   out_row_accept_i   row consumed when valid and accept are both high
//   out_row_last_o     presented row is row HEIGHT-1 of its image
//   out_row_tag_o      image tag of the presented row
//   frame_err_o        sticky framing error
//
// Optional feature: define IMG_ASM_FRAME_CHECK_EN to compare in_pixel_last_i
// against the counted image position. Without it in_pixel_last_i is ignored
// and frame_err_o stays 0.
// -----------------------------------------------------------------------------
module pixel_row_assembler #(
  parameter int VALUE_BITS = 8,
  parameter int WIDTH      = 28,
  parameter int HEIGHT     = 28,
  parameter int CHANNELS   = 1,
  parameter int TAG_WIDTH  = 6
) (
  input  logic                                         clock_i,
  input  logic                                         reset_i,
  input  logic [CHANNELS-1:0][VALUE_BITS-1:0]          in_pixel_i,
  input  logic                                         in_pixel_valid_i,
  output logic                                         in_pixel_accept_o,
  input  logic                                         in_pixel_last_i,
  output logic [WIDTH-1:0][CHANNELS-1:0][VALUE_BITS-1:0] out_row_o,
  output logic                                         out_row_valid_o,
  input  logic                                         out_row_accept_i,
  output logic                                         out_row_last_o,
  output logic [TAG_WIDTH-1:0]                         out_row_tag_o,
  output logic                                         frame_err_o
);

  localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

  typedef logic [WIDTH-1:0][CHANNELS-1:0][VALUE_BITS-1:0] row_t;

  logic [COL_W-1:0]     col_q, col_d;
  logic [ROW_W-1:0]     row_q, row_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  row_t                 fill_q, fill_d;
  row_t                 out_row_q, out_row_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_last_q, out_last_d;
  logic [TAG_WIDTH-1:0] out_tag_q, out_tag_d;
  // Completed row parked in the fill buffer, with its attributes frozen at
  // completion time so a later tag increment does not leak into it.
  logic                 pending_q, pending_d;
  logic                 pend_last_q, pend_last_d;
  logic [TAG_WIDTH-1:0] pend_tag_q, pend_tag_d;
  logic                 frame_err_q, frame_err_d;

  logic pix_hs;
  logic out_hs;
  logic slot_free;
  logic frame_abort;
  logic frame_miss;
  row_t row_load;

  assign in_pixel_accept_o = !reset_i && !pending_q;
  assign pix_hs            = in_pixel_valid_i && in_pixel_accept_o;
  assign out_hs            = out_valid_q && out_row_accept_i;
  assign slot_free         = !out_valid_q || out_row_accept_i;

  // Row as it looks at completion: the final pixel is still on the input
  // port, so it bypasses the fill buffer into the last slot.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_load
    if (gi == WIDTH - 1) begin : g_bypass
      assign row_load[gi] = in_pixel_i;
    end else begin : g_fill
      assign row_load[gi] = fill_q[gi];
    end
  end

`ifdef IMG_ASM_FRAME_CHECK_EN
  logic at_img_end;
  assign at_img_end  = (col_q == COL_LAST) && (row_q == ROW_LAST);
  assign frame_abort = in_pixel_last_i && !at_img_end;
  assign frame_miss  = !in_pixel_last_i && at_img_end;
`else
  logic unused_last;
  assign unused_last = in_pixel_last_i;
  assign frame_abort = 1'b0;
  assign frame_miss  = 1'b0;
`endif

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    tag_d       = tag_q;
    fill_d      = fill_q;
    out_row_d   = out_row_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_tag_d   = out_tag_q;
    pending_d   = pending_q;
    pend_last_d = pend_last_q;
    pend_tag_d  = pend_tag_q;
    frame_err_d = frame_err_q;

    if (out_hs) begin
      out_valid_d = 1'b0;
    end

    // Parked row moves up as soon as the output register is consumed; pixel
    // intake is blocked while pending, so this never collides with a fill.
    if (pending_q && out_hs) begin
      out_row_d   = fill_q;
      out_valid_d = 1'b1;
      out_last_d  = pend_last_q;
      out_tag_d   = pend_tag_q;
      pending_d   = 1'b0;
    end

    if (pix_hs) begin
      fill_d[col_q] = in_pixel_i;
      if (frame_abort) begin
        // Early end of image: drop the partial row and start a new image.
        col_d       = '0;
        row_d       = '0;
        tag_d       = tag_q + 1'b1;
        frame_err_d = 1'b1;
      end else begin
        if (frame_miss) begin
          frame_err_d = 1'b1;
        end
        if (col_q == COL_LAST) begin
          col_d = '0;
          if (row_q == ROW_LAST) begin
            row_d = '0;
            tag_d = tag_q + 1'b1;
          end else begin
            row_d = row_q + 1'b1;
          end
          if (slot_free) begin
            out_row_d   = row_load;
            out_valid_d = 1'b1;
            out_last_d  = (row_q == ROW_LAST);
            out_tag_d   = tag_q;
          end else begin
            pending_d   = 1'b1;
            pend_last_d = (row_q == ROW_LAST);
            pend_tag_d  = tag_q;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      col_q       <= '0;
      row_q       <= '0;
      tag_q       <= '0;
      fill_q      <= '0;
      out_row_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_tag_q   <= '0;
      pending_q   <= 1'b0;
      pend_last_q <= 1'b0;
      pend_tag_q  <= '0;
      frame_err_q <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      tag_q       <= tag_d;
      fill_q      <= fill_d;
      out_row_q   <= out_row_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_tag_q   <= out_tag_d;
      pending_q   <= pending_d;
      pend_last_q <= pend_last_d;
      pend_tag_q  <= pend_tag_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign out_row_o       = out_row_q;
  assign out_row_valid_o = out_valid_q;
  assign out_row_last_o  = out_last_q;
  assign out_row_tag_o   = out_tag_q;
  assign frame_err_o     = frame_err_q;

endmodule

// File: tb/tb_pixel_row_assembler.sv
// -----------------------------------------------------------------------------
// tb_pixel_row_assembler
//
// Directed sequence of stimulus phases with random pixel data and random
// handshake patterns. A reference model tracks the flat pixel position within
// the image and keeps a queue of rows that should be visible downstream; the
// DUT is compared against it every cycle.
// -----------------------------------------------------------------------------
module tb_pixel_row_assembler;

  localparam int VB = 8;
  localparam int W  = 28;
  localparam int H  = 28;
  localparam int CH = 1;
  localparam int TW = 2;

  typedef logic [W-1:0][CH-1:0][VB-1:0] row_t;
  typedef struct {
    row_t          data;
    bit            last;
    logic [TW-1:0] tag;
  } exp_row_t;

`ifdef IMG_ASM_FRAME_CHECK_EN
  localparam bit FC = 1'b1;
`else
  localparam bit FC = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   reset_i;
  logic [CH-1:0][VB-1:0]  in_pixel_i;
  logic                   in_pixel_valid_i;
  logic                   in_pixel_accept_o;
  logic                   in_pixel_last_i;
  row_t                   out_row_o;
  logic                   out_row_valid_o;
  logic                   out_row_accept_i;
  logic                   out_row_last_o;
  logic [TW-1:0]          out_row_tag_o;
  logic                   frame_err_o;

  always #5 clk = ~clk;

  pixel_row_assembler #(
    .VALUE_BITS (VB),
    .WIDTH      (W),
    .HEIGHT     (H),
    .CHANNELS   (CH),
    .TAG_WIDTH  (TW)
  ) dut (
    .clock_i           (clk),
    .reset_i           (reset_i),
    .in_pixel_i        (in_pixel_i),
    .in_pixel_valid_i  (in_pixel_valid_i),
    .in_pixel_accept_o (in_pixel_accept_o),
    .in_pixel_last_i   (in_pixel_last_i),
    .out_row_o         (out_row_o),
    .out_row_valid_o   (out_row_valid_o),
    .out_row_accept_i  (out_row_accept_i),
    .out_row_last_o    (out_row_last_o),
    .out_row_tag_o     (out_row_tag_o),
    .frame_err_o       (frame_err_o)
  );

  int            n_cmp = 0;
  int            n_err = 0;
  exp_row_t      exp_q[$];
  row_t          cur_row = '0;
  int            pix_idx = 0;
  int            img = 0;
  bit            exp_err = 1'b0;
  int            rows_seen = 0;
  logic [TW-1:0] last_tags[$];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_at_end();
    return pix_idx == W * H - 1;
  endfunction

  task automatic check_outputs(input bit rst);
    chk("pix_accept", in_pixel_accept_o, !rst && (exp_q.size() < 2));
    chk("row_valid", out_row_valid_o, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      chk("row_data", out_row_o, exp_q[0].data);
      chk("row_last", out_row_last_o, exp_q[0].last);
      chk("row_tag", out_row_tag_o, exp_q[0].tag);
    end
    chk("frame_err", frame_err_o, exp_err);
  endtask

  // Reference behaviour at the clock edge, in terms of image position.
  task automatic model_update(input bit rst, input bit hs, input bit pop,
                              input bit lst, input logic [VB-1:0] pix);
    bit at_end;
    exp_row_t e;
    if (rst) begin
      exp_q.delete();
      pix_idx = 0;
      img     = 0;
      exp_err = 1'b0;
      cur_row = '0;
      return;
    end
    if (pop) void'(exp_q.pop_front());
    if (hs) begin
      at_end = (pix_idx == W * H - 1);
      if (FC && lst && !at_end) begin
        exp_err = 1'b1;
        img++;
        pix_idx = 0;
        return;
      end
      if (FC && !lst && at_end) exp_err = 1'b1;
      cur_row[pix_idx % W] = pix;
      if (pix_idx % W == W - 1) begin
        e.data = cur_row;
        e.last = (pix_idx / W == H - 1);
        e.tag  = img[TW-1:0];
        exp_q.push_back(e);
      end
      pix_idx++;
      if (pix_idx == W * H) begin
        pix_idx = 0;
        img++;
      end
    end
  endtask

  task automatic drive_cycle(input bit rst, input bit vld, input bit acc, input bit lst,
                             input logic [VB-1:0] pix, input bit do_chk);
    bit hs;
    bit pop;
    reset_i          = rst;
    in_pixel_valid_i = vld;
    out_row_accept_i = acc;
    in_pixel_last_i  = lst;
    in_pixel_i       = pix;
    #1;
    if (do_chk) begin
      check_outputs(rst);
      if (out_row_valid_o && acc) begin
        rows_seen++;
        if (out_row_last_o) last_tags.push_back(out_row_tag_o);
      end
    end
    hs  = vld && !rst && (exp_q.size() < 2);
    pop = acc && !rst && (exp_q.size() > 0);
    @(posedge clk);
    model_update(rst, hs, pop, lst, pix);
    @(negedge clk);
  endtask

  initial begin
    logic [TW-1:0] want_tags [5];
    want_tags = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    reset_i          = 1'b1;
    in_pixel_valid_i = 1'b0;
    out_row_accept_i = 1'b0;
    in_pixel_last_i  = 1'b0;
    in_pixel_i       = '0;

    // Reset state
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    chk("rst_data", out_row_o, '0);
    chk("rst_tag", out_row_tag_o, '0);
    chk("rst_last", out_row_last_o, 1'b0);

    // One image with the counting pattern, everything held ready
    rows_seen = 0;
    for (int i = 0; i < W * H + 2; i++)
      drive_cycle(1'b0, i < W * H, 1'b1, model_at_end(), 8'(pix_idx), 1'b1);
    chk("img0_rows", rows_seen, 28);

    // Downstream stall: row 1 parks, intake stops, then drains in order
    for (int i = 0; i < 40 && exp_q.size() == 0; i++)
      drive_cycle(1'b0, 1'b1, 1'b0, model_at_end(), 8'($urandom), 1'b1);
    for (int i = 0; i < 100; i++)
      drive_cycle(1'b0, 1'b1, 1'b0, model_at_end(), 8'($urandom), 1'b1);
    chk("stall_q", exp_q.size(), 2);
    for (int i = 0; i < 60; i++)
      drive_cycle(1'b0, 1'b1, 1'b1, model_at_end(), 8'($urandom), 1'b1);

    // Output accepted in the very cycle the next row completes
    for (int i = 0; i < 4 * W; i++)
      drive_cycle(1'b0, 1'b1, (pix_idx % W) == W - 1, model_at_end(), 8'($urandom), 1'b1);

    // Five back-to-back images: tags wrap at 2 bits
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    last_tags.delete();
    for (int i = 0; i < 5 * W * H + 2; i++)
      drive_cycle(1'b0, 1'b1, 1'b1, model_at_end(), 8'($urandom), 1'b1);
    chk("last_count", last_tags.size(), 5);
    for (int i = 0; i < 5 && i < last_tags.size(); i++)
      chk($sformatf("last_tag%0d", i), last_tags[i], want_tags[i]);

    // Random valid / accept
    for (int i = 0; i < 1500; i++)
      drive_cycle(1'b0, ($urandom % 4) != 0, ($urandom % 2) == 1, model_at_end(),
                  8'($urandom), 1'b1);

    // Reset in the middle of row 5 of an image
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    for (int i = 0; i < 5 * W + 10; i++)
      drive_cycle(1'b0, 1'b1, 1'b1, model_at_end(), 8'($urandom), 1'b1);
    drive_cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'($urandom), 1'b1);
    chk("midrst_valid", out_row_valid_o, 1'b0);
    chk("midrst_data", out_row_o, '0);
    chk("midrst_tag", out_row_tag_o, '0);
    rows_seen = 0;
    for (int i = 0; i < W * H + 2; i++)
      drive_cycle(1'b0, 1'b1, 1'b1, model_at_end(), 8'($urandom), 1'b1);
    chk("midrst_rows", rows_seen, 28);

    // Early end-of-image marker on pixel 100
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    for (int i = 0; i < 100; i++)
      drive_cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'($urandom), 1'b1);
    drive_cycle(1'b0, 1'b1, 1'b1, 1'b1, 8'($urandom), 1'b1);
    chk("early_last_err", frame_err_o, exp_err);
    for (int i = 0; i < 3 * W + 2; i++)
      drive_cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'($urandom), 1'b1);

    // Missing end-of-image marker on the final pixel
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    for (int i = 0; i < W * H + 2; i++)
      drive_cycle(1'b0, i < W * H, 1'b1, 1'b0, 8'($urandom), 1'b1);
    chk("miss_last_err", frame_err_o, exp_err);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
